// File: rtl/input_source_arbiter.sv
// Player-control ownership arbiter between debounced buttons and UART.
// One source owns the controls; ownership is released after an idle timeout.
//
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   force_mode [1:0]  : 00/11 auto, 01 force buttons, 10 force UART
//   btn_ctrl [3:0]    : {p2_down, p2_up, p1_down, p1_up} button levels
//   btn_start         : button start pulse
//   uart_ctrl [3:0]   : UART levels, same order as btn_ctrl
//   uart_start        : UART start pulse
//   p1_up..p2_down    : registered owner controls
//   start_trigger     : registered owner start pulse
//   input_mode [1:0]  : current owner, 00 none, 01 buttons, 10 UART
module input_source_arbiter #(
  parameter int unsigned CLK_FREQ        = 50000000,
  parameter int unsigned IDLE_TIMEOUT_MS = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] force_mode,
  input  logic [3:0] btn_ctrl,
  input  logic       btn_start,
  input  logic [3:0] uart_ctrl,
  input  logic       uart_start,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       start_trigger,
  output logic [1:0] input_mode
);

  localparam int unsigned DIV = CLK_FREQ / 1000;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [15:0]   MS_LAST    = 16'(IDLE_TIMEOUT_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BTN  = 2'b01,
    S_UART = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0] ms_q, ms_d;
  logic [1:0]  fm_q;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        start_q, start_d;

  logic btn_act;
  logic uart_act;
  logic own_act;
  logic fm_chg;
  logic clr;

  assign btn_act  = (|btn_ctrl) | btn_start;
  assign uart_act = (|uart_ctrl) | uart_start;
  assign fm_chg   = (force_mode != fm_q);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    own_act = 1'b0;
    clr     = 1'b0;

    unique case (1'b1)
      (force_mode == 2'b01): begin
        state_d = S_BTN;
        clr     = 1'b1;
      end
      (force_mode == 2'b10): begin
        state_d = S_UART;
        clr     = 1'b1;
      end
      default: begin
        case (state_q)
          S_BTN:   own_act = btn_act;
          S_UART:  own_act = uart_act;
          default: own_act = 1'b0;
        endcase
        if (state_q != S_BTN && state_q != S_UART) begin
          // No owner: buttons take priority on a simultaneous claim.
          clr = 1'b1;
          if (btn_act)
            state_d = S_BTN;
          else if (uart_act)
            state_d = S_UART;
          else
            state_d = S_IDLE;
        end else if (own_act || fm_chg) begin
          // A mode change back to auto starts a fresh idle count.
          clr = 1'b1;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (ms_q >= MS_LAST) begin
            state_d = S_IDLE;
            ms_d    = '0;
          end else begin
            ms_d = ms_q + 16'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    endcase

    if (clr) begin
      presc_d = '0;
      ms_d    = '0;
    end
  end

  // Outputs follow the owner chosen this cycle so a claim forwards its inputs.
  always_comb begin
    ctrl_d  = 4'b0000;
    start_d = 1'b0;
    case (state_d)
      S_BTN: begin
        ctrl_d  = btn_ctrl;
        start_d = btn_start;
      end
      S_UART: begin
        ctrl_d  = uart_ctrl;
        start_d = uart_start;
      end
      default: begin
        ctrl_d  = 4'b0000;
        start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      ms_q    <= '0;
      fm_q    <= 2'b00;
      ctrl_q  <= 4'b0000;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      fm_q    <= force_mode;
      ctrl_q  <= ctrl_d;
      start_q <= start_d;
    end
  end

  assign p1_up         = ctrl_q[0];
  assign p1_down       = ctrl_q[1];
  assign p2_up         = ctrl_q[2];
  assign p2_down       = ctrl_q[3];
  assign start_trigger = start_q;
  assign input_mode    = state_q;

endmodule
